// File: rtl/vc_pop_arbiter.sv
// Two-VC pop arbiter: VC0 priority with a burst limit that lets VC1 through,
// back-pressure pause, and one-cycle delayed pop enables for the output mux.
module vc_pop_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       empty_VC0,
  input  logic       empty_VC1,
  input  logic       almost_full_out,
  output logic       pop_VC0,
  output logic       pop_VC1,
  output logic       pop_delay_VC0,
  output logic       pop_delay_VC1,
  output logic       valid_out,
  output logic [1:0] state
);
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    PAUSE  = 2'b10,
    BAD    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  state_t           st;
  logic [CNT_W-1:0] burst_cnt;
  logic             go, starve, any_req;

  assign any_req   = !empty_VC0 || !empty_VC1;
  // reset gating keeps the FIFOs from being drained while registers clear
  assign go        = !reset && (st != PAUSE) && !almost_full_out;
  assign starve    = (burst_cnt == BURST_MAX) && !empty_VC1;
  assign pop_VC0   = go && !empty_VC0 && !starve;
  assign pop_VC1   = go && !empty_VC1 && !pop_VC0;
  assign valid_out = pop_delay_VC0 | pop_delay_VC1;
  assign state     = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= IDLE;
      burst_cnt     <= '0;
      pop_delay_VC0 <= 1'b0;
      pop_delay_VC1 <= 1'b0;
    end else begin
      pop_delay_VC0 <= pop_VC0;
      pop_delay_VC1 <= pop_VC1;

      // IDLE, ACTIVE and PAUSE share one next-state rule; 2'b11 falls back to IDLE
      case (st)
        IDLE, ACTIVE, PAUSE: begin
          if (almost_full_out) st <= PAUSE;
          else if (any_req)    st <= ACTIVE;
          else                 st <= IDLE;
        end
        default: st <= IDLE;
      endcase

      if (pop_VC1 || empty_VC1)
        burst_cnt <= '0;
      else if (pop_VC0 && burst_cnt != BURST_MAX)
        burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter with word-count FIFO models on both VCs.
module tb_vc_pop_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       almost_full_out = 1'b0;
  logic       empty_VC0, empty_VC1;
  logic       pop_VC0, pop_VC1, pop_delay_VC0, pop_delay_VC1, valid_out;
  logic [1:0] state;

  int cnt0 = 0;
  int cnt1 = 0;
  int checks = 0;
  int errors = 0;
  int order[$];

  assign empty_VC0 = (cnt0 == 0);
  assign empty_VC1 = (cnt1 == 0);

  vc_pop_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .empty_VC0(empty_VC0), .empty_VC1(empty_VC1),
    .almost_full_out(almost_full_out),
    .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
    .pop_delay_VC0(pop_delay_VC0), .pop_delay_VC1(pop_delay_VC1),
    .valid_out(valid_out), .state(state)
  );

  always #5 clk = ~clk;

  // FIFO word counters; pops are logged in issue order
  always @(posedge clk) begin
    if (pop_VC0 || pop_VC1) begin
      checks++;
      if ((pop_VC0 && pop_VC1) || (pop_VC0 && cnt0 == 0) || (pop_VC1 && cnt1 == 0)) begin
        errors++;
        $display("FAIL pop_legal: pop0=%0b pop1=%0b cnt0=%0d cnt1=%0d", pop_VC0, pop_VC1, cnt0, cnt1);
      end
    end
    if (pop_VC0 && cnt0 > 0) begin cnt0 <= cnt0 - 1; order.push_back(0); end
    if (pop_VC1 && cnt1 > 0) begin cnt1 <= cnt1 - 1; order.push_back(1); end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    almost_full_out = 1'b0;
    cnt0 = 0;
    cnt1 = 0;
    tick();
    tick();
    reset = 1'b0;
    order.delete();
  endtask

  task automatic check_order(input string name, input int exp[$]);
    checks++;
    if (order.size() != exp.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d want %0d", name, order.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (order[i] != exp[i]) begin
          errors++;
          $display("FAIL %s[%0d]: got %0d want %0d", name, i, order[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cnt0 = 5;
    cnt1 = 5;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({pop_VC0, pop_VC1} !== 2'b00) begin
        errors++;
        $display("FAIL reset_pop: got %b want 00", {pop_VC0, pop_VC1});
      end
      tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({state, pop_delay_VC0, pop_delay_VC1, valid_out} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state: got state=%b d0=%b d1=%b v=%b want 00 0 0 0",
               state, pop_delay_VC0, pop_delay_VC1, valid_out);
    end
  endtask

  task automatic test_vc0_only();
    logic exp_pop[5]   = '{1, 1, 1, 0, 0};
    logic exp_dly[5]   = '{0, 1, 1, 1, 0};
    logic [1:0] exp_st[5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    do_reset();
    cnt0 = 3;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (pop_VC0 !== exp_pop[c] || pop_delay_VC0 !== exp_dly[c] || state !== exp_st[c] ||
          dut.burst_cnt !== 4'd0 || pop_VC1 !== 1'b0) begin
        errors++;
        $display("FAIL vc0_only c%0d: got pop=%b dly=%b st=%b bc=%0d want pop=%b dly=%b st=%b bc=0",
                 c + 1, pop_VC0, pop_delay_VC0, state, dut.burst_cnt, exp_pop[c], exp_dly[c], exp_st[c]);
      end
      tick();
    end
  endtask

  task automatic test_backlog();
    int exp[$] = '{0,0,0,0,1, 0,0,0,0,1, 0,0,1,1,1, 1,1,1,1,1};
    do_reset();
    cnt0 = 10;
    cnt1 = 10;
    for (int c = 0; c < 20; c++) tick();
    check_order("backlog", exp);
  endtask

  task automatic test_backpressure();
    logic exp_pop, exp_v;
    logic [1:0] exp_st;
    do_reset();
    cnt0 = 12;
    for (int c = 1; c <= 12; c++) begin
      almost_full_out = (c >= 5 && c <= 7);
      #1;
      exp_pop = !(c >= 5 && c <= 8);
      exp_v   = (c >= 2 && c <= 5) || (c >= 10);
      exp_st  = (c == 1) ? 2'b00 : (c >= 6 && c <= 8) ? 2'b10 : 2'b01;
      checks++;
      if (pop_VC0 !== exp_pop || valid_out !== exp_v || state !== exp_st) begin
        errors++;
        $display("FAIL backpressure c%0d: got pop=%b v=%b st=%b want pop=%b v=%b st=%b",
                 c, pop_VC0, valid_out, state, exp_pop, exp_v, exp_st);
      end
      tick();
    end
    almost_full_out = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (order.size() != 12 || cnt0 != 0) begin
      errors++;
      $display("FAIL bp_words: got popped=%0d left=%0d want popped=12 left=0", order.size(), cnt0);
    end
  endtask

  task automatic test_reset_mid();
    int exp[$] = '{0,0,0,0,1,0};
    do_reset();
    cnt0 = 20;
    cnt1 = 5;
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (dut.burst_cnt !== 4'd3) begin
      errors++;
      $display("FAIL mid_pre_burst: got %0d want 3", dut.burst_cnt);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({pop_VC0, pop_VC1} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_pop: got %b want 00", {pop_VC0, pop_VC1});
    end
    tick();
    reset = 1'b0;
    order.delete();
    for (int c = 0; c < 6; c++) tick();
    check_order("reset_mid", exp);
  endtask

  task automatic test_last_word();
    int exp[$] = '{0,0,0,0,1,0,0,0,0};
    do_reset();
    cnt0 = 8;
    cnt1 = 1;
    for (int c = 0; c < 12; c++) tick();
    check_order("last_word", exp);
    checks++;
    if (dut.burst_cnt !== 4'd0 || state !== 2'b00) begin
      errors++;
      $display("FAIL last_word_end: got bc=%0d st=%b want bc=0 st=00", dut.burst_cnt, state);
    end
  endtask

  initial begin
    test_reset();
    test_vc0_only();
    test_backlog();
    test_backpressure();
    test_reset_mid();
    test_last_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vc_pop_arbiter.md
# vc_pop_arbiter

Controller for the two-virtual-channel output mux. It arbitrates reads from the VC0 and VC1 FIFOs using VC0 priority with an anti-starvation burst limit. It throttles on downstream back-pressure and generates the one-cycle-delayed `pop_delay_VC0`/`pop_delay_VC1` enables that drive the mux select. It sits between the VC FIFOs' status flags and the mux in front of the demux stage.

## Interface
- `MAX_BURST`, default 4: max consecutive VC0 pops while VC1 is non-empty; legal range 1..15.
- `CNT_W`, default 4: burst counter width; must hold `MAX_BURST`.

- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `empty_VC0` input 1: VC0 FIFO empty flag.
- `empty_VC1` input 1: VC1 FIFO empty flag.
- `almost_full_out` input 1: downstream back-pressure; 1 = stop popping.
- `pop_VC0` output 1: combinational read strobe to VC0 FIFO.
- `pop_VC1` output 1: combinational read strobe to VC1 FIFO.
- `pop_delay_VC0` output 1: registered `pop_VC0`, to mux enable.
- `pop_delay_VC1` output 1: registered `pop_VC1`, to mux enable.
- `valid_out` output 1: `pop_delay_VC0 | pop_delay_VC1`; mux output is valid.
- `state` output 2: FSM state, for debug and bench checking.

## Operation
- FSM states: IDLE=2'b00, ACTIVE=2'b01, PAUSE=2'b10; 2'b11 is illegal and recovers to IDLE next cycle.
- IDLE transitions:
  - `almost_full_out` → PAUSE.
  - else either FIFO non-empty → ACTIVE.
  - else stay in IDLE.
- ACTIVE transitions:
  - `almost_full_out` → PAUSE.
  - else both FIFOs empty → IDLE.
  - else stay in ACTIVE.
- PAUSE transitions:
  - stay while `almost_full_out` = 1.
  - once it is 0: → ACTIVE if either FIFO non-empty, else → IDLE.
- `go` = (state != PAUSE) & !`almost_full_out`.
- `starve` = (burst_cnt == MAX_BURST) & !`empty_VC1`.
- `pop_VC0` = `go` & !`empty_VC0` & !`starve`.
- `pop_VC1` = `go` & !`empty_VC1` & !`pop_VC0`.
- `pop_VC0` and `pop_VC1` are mutually exclusive. No pop is ever issued to an empty FIFO.
- burst_cnt, CNT_W bits, updates on each rising edge:
  - `pop_VC1` → 0.
  - `empty_VC1` = 1 → 0.
  - `pop_VC0` with VC1 non-empty → +1, saturating at MAX_BURST.
  - else hold.
- `pop_delay_VCx` <= `pop_VCx`. This models the one-cycle FIFO read latency, so the mux select lines up with FIFO data.

## Timing
- Reset values: state=IDLE, burst_cnt=0, `pop_delay_VC0`=0, `pop_delay_VC1`=0, `valid_out`=0.
- `pop_VC0`/`pop_VC1` are 0 during any cycle where `reset`=1.
- Reset asserted mid-stream: all registers clear at the next edge. Arbitration restarts with VC0 priority and burst_cnt=0.
- Pop latency: a FIFO flag going non-empty in cycle n (state IDLE or ACTIVE, no back-pressure) gives a pop in cycle n. Mux data is valid in cycle n+1.
- Back-pressure assert:
  - `almost_full_out` rising in cycle n kills pops in cycle n (combinational).
  - state = PAUSE from cycle n+1.
  - `valid_out` = 0 from cycle n+1.
- Back-pressure release:
  - `almost_full_out` falling in cycle m: state is still PAUSE in m, no pops.
  - pops resume in cycle m+1, so there is one recovery bubble.
- Simultaneous events: back-pressure overrides all requests. Starvation override applies only when VC1 is non-empty.
- Throughput: one pop per cycle sustained, with no bubbles between channel switches.

## Test plan
- Reset: hold `reset` 2 cycles with both FIFOs non-empty → `pop_*`=0 throughout. After release, `state`=00, `pop_delay_*`=0, `valid_out`=0.
- VC0 only: 3 words, VC1 empty, MAX_BURST=4 → `pop_VC0` high 3 consecutive cycles, burst_cnt stays 0. `pop_delay_VC0` high for cycles 2–4, then state returns to IDLE.
- Both channels backlogged: 10 words each, MAX_BURST=4 → pop order 0,0,0,0,1,0,0,0,0,1,… until VC0 drains, then all remaining VC1 back-to-back.
- Back-pressure: `almost_full_out` high at cycle 5 for 3 cycles during a VC0 stream → no pop in cycles 5–8, state=10 in cycles 6–8, pops resume at cycle 9, and no word is lost or duplicated.
- Reset mid-burst: assert `reset` when burst_cnt=3 → after release, VC0 gets 4 further consecutive pops before the first VC1 pop.
- Last-word boundary: VC1 holds 1 word, VC0 holds 8, burst at MAX_BURST → the VC1 word is popped, then VC0 continues with burst_cnt=0, and `pop_VC1` never asserts while `empty_VC1`=1.
